c_regfile_wr_sched: RTL
=======================

// Module: c_regfile_wr_sched
// PURPOSE
//  - Shares the single write port of a c_regfile (num_write_ports=1) among
//    num_requesters write clients, using round-robin arbitration and a
//    valid/ready handshake.
//  - Registers the granted write, tracks per-entry valid bits and bypasses the
//    in-flight write onto one read port.
//  - Sits between router-side producers (e.g. credit/state updaters) and the
//    regfile instance.
// PARAMETERS
//  depth          8   regfile entries (>=2); addr_width = clogb(depth)
//  width          64  bits per entry
//  num_requesters 4   write clients (>=1)
// PORTS
//  clk              in  1                    clock; all state on posedge
//  reset            in  1                    synchronous, active-low (0 = reset)
//  req_valid        in  num_requesters       client i has a write pending
//  req_addr         in  num_requesters*addr_width  client i target entry
//  req_data         in  num_requesters*width       client i write data
//  req_ready        out num_requesters       one-hot grant; transfer = valid&ready
//  clear            in  1                    invalidate all entry_valid bits
//  rf_write_active  out 1                    to regfile write_active
//  rf_write_enable  out 1                    to regfile write_enable
//  rf_write_address out addr_width           to regfile write_address
//  rf_write_data    out width                to regfile write_data
//  rd_address       in  addr_width           read address; also drives regfile read_address
//  rf_read_data     in  width                regfile read_data for rd_address
//  rd_data          out width                bypassed read data
//  rd_valid         out 1                    entry at rd_address holds written data
//  entry_valid      out depth                per-entry written-since-clear bits
//  error_addr       out 1                    sticky: accepted a req_addr >= depth
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - stage valid=0; rr priority=client 0; entry_valid=0; error_addr=0.
//    - req_ready=0 while reset==0 (combinational gate).
//  - Arbitration (combinational):
//    - Grant = first req_valid at or after priority pointer, wrapping modulo N.
//    - req_ready is the one-hot grant; it never depends on downstream state,
//      because the stage drains every cycle.
//  - Pointer update: on a transfer by client g, priority <= (g+1) mod N.
//    No transfer leaves priority unchanged.
//  - Stage: on a transfer, stg_vld<=1 and stg_addr/stg_data<=granted addr/data;
//    otherwise stg_vld<=0.
//  - Regfile drive:
//    - rf_write_active = rf_write_enable = stg_vld & (stg_addr<depth).
//    - rf_write_address/data = stage values.
//    - Accept -> regfile updated at the 2nd posedge.
//  - Out-of-range address: the accepted request is dropped (no write, no valid
//    set) and error_addr<=1. error_addr clears only on reset.
//  - entry_valid[a] <= 1 when the stage commits to entry a.
//    - clear zeroes all bits at the next edge.
//    - clear and a commit in the same cycle: the committed entry ends 1, all
//      others end 0 (write wins).
//  - Bypass (combinational):
//    - hit = stg_vld & stg_addr==rd_address & stg_addr<depth.
//    - rd_data = hit ? stg_data : rf_read_data.
//    - rd_valid = hit | entry_valid[rd_address].
//  - Same-address requests from several clients are serialized in rr order;
//    the last writer wins.
//  - Reset mid-operation: the in-flight stage write is discarded (not committed).
// STRUCTURE
//  - clogb and the REGFILE_TYPE_* constants come from the shared
//    c_functions/c_constants include set.
//  - No new typedefs.
//  - One sub-module: c_rr_arbiter_ptr. Inputs: req vector and pointer.
//    Outputs: one-hot grant and next pointer. It is reusable by the other
//    schedulers.
//  - A top-level wrapper instantiates c_regfile with regfile_type
//    REGFILE_TYPE_FF_2D.
// TESTING
//  1. Reset held 3 cycles with all req_valid=1 -> req_ready=0000,
//     rf_write_enable=0, entry_valid=0.
//  2. req_valid=1111 held 8 cycles -> grants 1000,0100,0010,0001,1000,...
//     Each grant is written one cycle later.
//  3. Client 2 writes addr 5 / data 0xA5 -> rf_write_enable=1, addr=5 the next
//     cycle. In that cycle rd_address=5 gives rd_data=0xA5, rd_valid=1 (bypass).
//  4. Clients 0 and 3 both write addr 1 (0x11, 0x33) with priority at 3 ->
//     order 3 then 0; final rd_data=0x11.
//  5. clear in the same cycle as the commit of addr 4 -> entry_valid=0000_1000
//     (entry 4 only).
//  6. depth=6, client 1 writes addr 7 -> accepted, rf_write_enable=0,
//     error_addr=1 and stays 1 until reset.

Source files
------------

// File: rtl/c_regfile_wr_sched_pkg.sv
// Shared constants and helpers for the regfile write scheduler.
package c_regfile_wr_sched_pkg;

  // Regfile implementation styles understood by c_regfile.
  localparam int REGFILE_TYPE_FF_2D  = 0;
  localparam int REGFILE_TYPE_FF_1D  = 1;
  localparam int REGFILE_TYPE_LATCH  = 2;
  localparam int REGFILE_TYPE_SRAM   = 3;

  // Ceiling log2. Returns 0 for value <= 1.
  function automatic int clogb(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/c_regfile_wr_sched_arb.sv
// Round-robin arbiter with an external priority pointer.
// The pointer is held by the caller, so several schedulers can reuse this
// block with their own pointer-update policy.
module c_rr_arbiter_ptr
  import c_regfile_wr_sched_pkg::*;
#(
  parameter int num_ports  = 4,
  parameter int ptr_width  = (num_ports > 1) ? clogb(num_ports) : 1
) (
  input  logic [num_ports-1:0] req,
  input  logic [ptr_width-1:0] ptr,
  output logic [num_ports-1:0] gnt,
  output logic [ptr_width-1:0] next_ptr
);

  logic found;
  int   idx;

  // Search from ptr upward with wraparound; first requester wins.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < num_ports; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_ports) idx = idx - num_ports;
      for (int j = 0; j < num_ports; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          next_ptr = (j + 1 == num_ports) ? '0 : ptr_width'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/c_regfile_wr_sched.sv
// Write-port scheduler for a single-write-port regfile: round-robin grant
// among clients, one register stage in front of the regfile, per-entry
// valid tracking and a read bypass of the in-flight write.
module c_regfile_wr_sched
  import c_regfile_wr_sched_pkg::*;
#(
  parameter int depth          = 8,
  parameter int width          = 64,
  parameter int num_requesters = 4,
  localparam int addr_width    = clogb(depth),
  localparam int ptr_width     = (num_requesters > 1) ? clogb(num_requesters) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_requesters-1:0]            req_valid,
  input  logic [num_requesters*addr_width-1:0] req_addr,
  input  logic [num_requesters*width-1:0]      req_data,
  output logic [num_requesters-1:0]            req_ready,
  input  logic                                 clear,
  output logic                                 rf_write_active,
  output logic                                 rf_write_enable,
  output logic [addr_width-1:0]                rf_write_address,
  output logic [width-1:0]                     rf_write_data,
  input  logic [addr_width-1:0]                rd_address,
  input  logic [width-1:0]                     rf_read_data,
  output logic [width-1:0]                     rd_data,
  output logic                                 rd_valid,
  output logic [depth-1:0]                     entry_valid,
  output logic                                 error_addr
);

  logic [ptr_width-1:0]      prio;
  logic [ptr_width-1:0]      next_prio;
  logic [num_requesters-1:0] gnt;
  logic                      xfer;
  logic [addr_width-1:0]     sel_addr;
  logic [width-1:0]          sel_data;
  logic                      stg_vld;
  logic [addr_width-1:0]     stg_addr;
  logic [width-1:0]          stg_data;
  logic                      stg_in_range;
  logic                      commit;
  logic                      hit;
  logic                      rd_entry_valid;

  c_rr_arbiter_ptr #(
    .num_ports (num_requesters),
    .ptr_width (ptr_width)
  ) u_arb (
    .req      (req_valid),
    .ptr      (prio),
    .gnt      (gnt),
    .next_ptr (next_prio)
  );

  // The stage drains every cycle, so the grant is never back-pressured.
  assign req_ready = reset ? gnt : '0;
  assign xfer      = |req_ready;

  // Select address and data of the granted client.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < num_requesters; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*addr_width +: addr_width];
        sel_data = req_data[i*width +: width];
      end
    end
  end

  assign stg_in_range = (32'(stg_addr) < depth);
  // Gating with reset discards an in-flight write when reset lands on it.
  assign commit       = stg_vld & stg_in_range & reset;

  assign rf_write_active  = commit;
  assign rf_write_enable  = commit;
  assign rf_write_address = stg_addr;
  assign rf_write_data    = stg_data;

  // Look up the valid bit for the read address without an out-of-range index.
  always_comb begin
    rd_entry_valid = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (rd_address == addr_width'(i)) rd_entry_valid = entry_valid[i];
    end
  end

  assign hit      = stg_vld & stg_in_range & (stg_addr == rd_address);
  assign rd_data  = hit ? stg_data : rf_read_data;
  assign rd_valid = hit | rd_entry_valid;

  // Stage register, priority pointer, valid bits and sticky address error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_vld     <= 1'b0;
      stg_addr    <= '0;
      stg_data    <= '0;
      prio        <= '0;
      entry_valid <= '0;
      error_addr  <= 1'b0;
    end else begin
      stg_vld <= xfer;
      if (xfer) begin
        stg_addr <= sel_addr;
        stg_data <= sel_data;
        prio     <= next_prio;
        if (32'(sel_addr) >= depth) error_addr <= 1'b1;
      end
      if (clear) entry_valid <= '0;
      for (int i = 0; i < depth; i++) begin
        if (commit && (stg_addr == addr_width'(i))) entry_valid[i] <= 1'b1;
      end
    end
  end

endmodule
